// File: rtl/mux_share_arbiter.sv
// Four-requester round-robin arbiter with a bounded hold time.
// The grant owner steers a shared 2-level 2:1 mux onto y.
module mux_share_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  input  logic [3:0] din,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid,
  output logic       y
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] hold_q, hold_d;
  logic       valid_q, valid_d;

  logic [1:0] rr_ptr, rr_idx;
  logic       rr_found;
  logic       release_now;
  logic       take;
  logic       mux_lo, mux_hi;

  // At a release the search starts just past the old owner, so it is considered last.
  assign rr_ptr      = (state_q == StGrant) ? sel_q + 2'd1 : ptr_q;
  assign release_now = (state_q == StGrant) && (!req[sel_q] || (hold_q == 4'(MAX_HOLD)));

  // Descending scan: the smallest offset from rr_ptr is assigned last and wins.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[rr_ptr + 2'(k)]) begin
        rr_found = 1'b1;
        rr_idx   = rr_ptr + 2'(k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    valid_d = valid_q;
    take    = 1'b0;
    case (state_q)
      StIdle: begin
        take = en && rr_found;
      end
      StGrant: begin
        if (release_now) begin
          ptr_d = sel_q + 2'd1;
          take  = en && rr_found;
          if (!take) begin
            state_d = StIdle;
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
            hold_d  = 4'd0;
          end
        end else if (hold_q != 4'hf) begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
      end
    endcase
    if (take) begin
      state_d = StGrant;
      sel_d   = rr_idx;
      gnt_d   = 4'b0001 << rr_idx;
      valid_d = 1'b1;
      hold_d  = 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      hold_q  <= 4'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
    end
  end

  // Shared datapath: sel[0] picks within each pair, sel[1] picks the pair.
  assign mux_lo = sel_q[0] ? din[1] : din[0];
  assign mux_hi = sel_q[0] ? din[3] : din[2];
  assign y      = valid_q & (sel_q[1] ? mux_hi : mux_lo);

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Scoreboard bench for mux_share_arbiter: MAX_HOLD=4 and MAX_HOLD=1 instances
// share stimulus and are each compared against a queue-fed reference model.
module tb_mux_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] req, din;
  logic [3:0] gnt4, gnt1;
  logic [1:0] sel4, sel1;
  logic       valid4, valid1, y4, y1;

  always #5 clk = ~clk;

  mux_share_arbiter #(.MAX_HOLD(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .din(din),
    .gnt(gnt4), .sel(sel4), .valid(valid4), .y(y4)
  );

  mux_share_arbiter #(.MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .din(din),
    .gnt(gnt1), .sel(sel1), .valid(valid1), .y(y1)
  );

  typedef struct {
    logic [3:0] g;
    logic [1:0] s;
    logic       v;
    logic       y;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model per instance: owner index (-1 = nobody), hold time, pointer, last sel.
  int m_owner[2];
  int m_hold[2];
  int m_ptr[2];
  int m_sel[2];
  int mh[2] = '{4, 1};

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = -1;
      m_hold[i]  = 0;
      m_ptr[i]   = 0;
      m_sel[i]   = 0;
    end
  endtask

  task automatic model_step(input int i, input logic e, input logic [3:0] r);
    bit may_grant;
    bit found;
    may_grant = 1'b1;
    if (m_owner[i] >= 0) begin
      if (!r[m_owner[i]] || m_hold[i] == mh[i]) begin
        m_ptr[i]   = (m_owner[i] + 1) % 4;
        m_owner[i] = -1;
      end else begin
        m_hold[i]  = (m_hold[i] < 15) ? m_hold[i] + 1 : 15;
        may_grant  = 1'b0;
      end
    end
    if (may_grant && e && r != 4'b0000) begin
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr[i] + k) % 4;
        if (!found && r[c]) begin
          found      = 1'b1;
          m_owner[i] = c;
          m_sel[i]   = c;
          m_hold[i]  = 1;
        end
      end
    end
  endtask

  function automatic exp_t model_out(input int i, input logic [3:0] d);
    exp_t e;
    e.v = (m_owner[i] >= 0);
    e.g = e.v ? 4'(1 << m_owner[i]) : 4'b0000;
    e.s = 2'(m_sel[i]);
    e.y = e.v ? d[m_sel[i]] : 1'b0;
    return e;
  endfunction

  task automatic push_expect(input logic e, input logic [3:0] r, input logic [3:0] d);
    for (int i = 0; i < 2; i++) model_step(i, e, r);
    q4.push_back(model_out(0, d));
    q1.push_back(model_out(1, d));
  endtask

  task automatic cycle(input logic e, input logic [3:0] r, input logic [3:0] d);
    @(negedge clk);
    en  = e;
    req = r;
    din = d;
    push_expect(e, r, d);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt4"}, gnt4, 4'b0000);
    check({tag, "_valid4"}, {3'b0, valid4}, 4'd0);
    check({tag, "_y4"}, {3'b0, y4}, 4'd0);
    check({tag, "_sel4"}, {2'b0, sel4}, 4'd0);
    check({tag, "_gnt1"}, gnt1, 4'b0000);
    check({tag, "_valid1"}, {3'b0, valid1}, 4'd0);
    check({tag, "_y1"}, {3'b0, y1}, 4'd0);
    check({tag, "_sel1"}, {2'b0, sel1}, 4'd0);
  endtask

  // Reset pulse strictly between edges, then set up inputs for the following edge.
  task automatic reset_pulse(input logic e, input logic [3:0] r, input logic [3:0] d);
    @(negedge clk);
    #1 rst_n = 1'b0;
    din = 4'hf;
    #1 check_reset_outputs("async_rst");
    model_reset();
    #1 rst_n = 1'b1;
    en  = e;
    req = r;
    din = d;
    push_expect(e, r, d);
  endtask

  // Monitor: compare the DUT against the oldest expectation after every edge.
  initial begin
    exp_t a, b;
    forever begin
      @(posedge clk);
      #1;
      if (q4.size() > 0) begin
        a = q4.pop_front();
        b = q1.pop_front();
        check("gnt4", gnt4, a.g);
        check("sel4", {2'b0, sel4}, {2'b0, a.s});
        check("valid4", {3'b0, valid4}, {3'b0, a.v});
        check("y4", {3'b0, y4}, {3'b0, a.y});
        check("onehot4", {3'b0, $countones(gnt4) <= 1}, 4'd1);
        check("gnt1", gnt1, b.g);
        check("sel1", {2'b0, sel1}, {2'b0, b.s});
        check("valid1", {3'b0, valid1}, {3'b0, b.v});
        check("y1", {3'b0, y1}, {3'b0, b.y});
        check("onehot1", {3'b0, $countones(gnt1) <= 1}, 4'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 4'b0000;
    din   = 4'hf;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");

    // V1: single requester, regrant at the hold limit with no bubble
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    req   = 4'b0100;
    din   = 4'b0100;
    push_expect(1'b1, 4'b0100, 4'b0100);
    repeat (10) cycle(1'b1, 4'b0100, 4'b0100);

    // V2: fairness with all requesting
    reset_pulse(1'b1, 4'b1111, 4'($urandom));
    repeat (20) cycle(1'b1, 4'b1111, 4'($urandom));

    // V3: early release by owner 1
    reset_pulse(1'b1, 4'b0010, 4'b1010);
    cycle(1'b1, 4'b0010, 4'b1010);
    repeat (4) cycle(1'b1, 4'b1001, 4'($urandom));

    // V4: enable gating, then en dropped mid-grant
    reset_pulse(1'b0, 4'b0011, 4'b0011);
    repeat (3) cycle(1'b0, 4'b0011, 4'b0011);
    cycle(1'b1, 4'b0011, 4'b0001);
    repeat (6) cycle(1'b0, 4'b0011, 4'($urandom));

    // V5: async reset while owner 1 holds the grant
    reset_pulse(1'b1, 4'b0010, 4'b0010);
    repeat (2) cycle(1'b1, 4'b0010, 4'b0010);
    reset_pulse(1'b1, 4'b0010, 4'b0010);
    repeat (2) cycle(1'b1, 4'b0010, 4'b0010);

    // V6: two requesters; the MAX_HOLD=1 instance alternates every cycle
    reset_pulse(1'b1, 4'b0101, 4'($urandom));
    repeat (8) cycle(1'b1, 4'b0101, 4'($urandom));

    // Random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 49) == 0) reset_pulse(1'b1, 4'($urandom), 4'($urandom));
      else cycle($urandom_range(0, 7) != 0, 4'($urandom), 4'($urandom));
    end

    @(posedge clk);
    #3;
    check("drain", 4'(q4.size()), 4'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_share_arbiter.md
MUX_SHARE_ARBITER -- requirements
Module: mux_share_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4, SHALL set the maximum consecutive cycles one requester may hold the grant; legal range 1..15.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 en  input  1  new-grant enable; when 0, no new grant SHALL be issued, but an existing grant SHALL run to release.
REQ-005 req  input  4  per-requester request, bit i = requester i.
REQ-006 din  input  4  per-requester data bit, bit i = requester i; feeds the shared 2-level 2:1 mux datapath.
REQ-007 gnt  output  4  one-hot grant, registered; all-zero when no owner.
REQ-008 sel  output  2  registered mux select equal to the owner index; sel[1] SHALL be the upper-level select and sel[0] the lower-level select.
REQ-009 valid  output  1  registered; 1 exactly when gnt is non-zero.
REQ-010 y  output  1  combinational shared output = din[sel] when valid=1, else 0.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE (no owner) and GRANT (owner = sel).
REQ-012 In IDLE with en=1 and req!=0, the owner SHALL be selected round-robin, and the FSM SHALL enter GRANT next cycle with hold_cnt=1.
- Round-robin order: ptr, ptr+1, ..., ptr+3 mod 4, first set req bit wins.
- Latency: req seen at edge N -> gnt/valid/sel at edge N+1.
REQ-013 In IDLE with en=0 or req=0, the FSM SHALL stay in IDLE, with gnt=0 and valid=0.
REQ-014 In GRANT, hold_cnt SHALL increment by 1 each cycle the owner keeps its grant, with saturating width of 4 bits.
REQ-015 Release SHALL occur at an edge where req[owner]=0 or hold_cnt==MAX_HOLD.
- At release, ptr SHALL become (owner+1) mod 4.
REQ-016 At release with en=1 and any req bit set, the FSM SHALL grant the next owner at that same edge, with no idle bubble.
- The next owner SHALL be the round-robin winner from the new ptr, and hold_cnt SHALL restart at 1.
- The old owner is eligible only if it still requests and no other requester does (it then regains the grant at hold_cnt=1).
REQ-017 At release with en=0 or no req, the FSM SHALL return to IDLE, with gnt=0 at the next cycle.
REQ-018 gnt SHALL never have more than one bit set, and sel SHALL hold its last value while valid=0.
REQ-019 With MAX_HOLD=1, ownership SHALL rotate every cycle among the active requesters.
REQ-020 A change to a non-owner req bit during GRANT SHALL NOT affect the current grant.

Reset
REQ-021 While rst_n=0, and immediately on its assertion (including mid-grant), the block SHALL force: state=IDLE, gnt=0, sel=0, valid=0, ptr=0, hold_cnt=0, and y=0.
REQ-022 The first grant decision SHALL occur at the first rising edge after rst_n deasserts.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- V1, single requester: reset, en=1, req=0100, din=0100 -> edge+1: gnt=0100, sel=10, valid=1, y=1; req held -> after 4 cycles, regrant at the same edge (gnt stays 0100, hold_cnt=1).
- V2, fairness: req=1111 held, MAX_HOLD=4 -> owners 0,1,2,3,0, each held exactly 4 cycles, no bubble, gnt one-hot every cycle.
- V3, early release: owner 1, req[1] dropped at cycle 2 with req=1001 -> next edge gnt=1000 (ptr=2 so 3 beats 0).
- V4, enable gating: en=0, req=0011 -> gnt stays 0000 and y=0; en=1 -> gnt=0001 at the next edge; en=0 mid-grant -> grant runs to release, then IDLE.
- V5, async reset mid-grant: rst_n pulsed low between edges while gnt=0010 -> gnt=0, valid=0, and y=0 immediately; after deassert with req=0010 -> gnt=0010 at the first edge.
- V6, MAX_HOLD=1 with req=0101 -> gnt alternates 0001, 0100, 0001 every cycle, and y tracks din[0], din[2], din[0].
